// File: rtl/dict_bank_scheduler.sv
// Round-robin time-sharing of one dictionary bank among NUM_REQ requesters: load dictionary, stream ids, route results.
// Optional counters perf_rounds/perf_lookups are enabled by DICT_BANK_SCHEDULER_PERF_EN (tied to 0 otherwise).
module dict_bank_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int VALUE_WIDTH  = 32,
  parameter int ID_WIDTH     = 10,
  parameter int SERIAL_WIDTH = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0]                            req_val_valid,
  input  logic [NUM_REQ-1:0]                            req_val_last,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0]                req_val_data,
  output logic [NUM_REQ-1:0]                            req_val_ready,
  input  logic [NUM_REQ-1:0]                            req_id_valid,
  input  logic [NUM_REQ-1:0]                            req_id_last,
  input  logic [NUM_REQ*(ID_WIDTH+SERIAL_WIDTH)-1:0]    req_id_data,
  output logic [NUM_REQ-1:0]                            req_id_ready,
  output logic [NUM_REQ-1:0]                            rsp_valid,
  output logic [VALUE_WIDTH+SERIAL_WIDTH-1:0]           rsp_data,
  output logic                                          rsp_last,
  input  logic [NUM_REQ-1:0]                            rsp_ready,
  output logic                                          bank_val_valid,
  output logic                                          bank_val_last,
  output logic [VALUE_WIDTH-1:0]                        bank_val_data,
  input  logic                                          bank_val_ready,
  output logic                                          bank_id_valid,
  output logic                                          bank_id_last,
  output logic [ID_WIDTH+SERIAL_WIDTH-1:0]              bank_id_data,
  input  logic                                          bank_id_ready,
  input  logic                                          bank_out_valid,
  input  logic                                          bank_out_last,
  input  logic [VALUE_WIDTH+SERIAL_WIDTH-1:0]           bank_out_data,
  output logic                                          bank_out_ready,
  output logic [NUM_REQ-1:0]                            grant,
  output logic                                          busy,
  output logic [31:0]                                   perf_rounds,
  output logic [31:0]                                   perf_lookups
);
  localparam int IW = ID_WIDTH + SERIAL_WIDTH;
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, LOOKUP, DRAIN} state_t;

  state_t        state, state_n;
  logic [PW-1:0] rr_ptr, gidx, pick_idx;
  logic [PW:0]   idx_w;
  logic          pick_found, round_end, id_fire;

  logic [NUM_REQ-1:0][VALUE_WIDTH-1:0] val_arr;
  logic [NUM_REQ-1:0][IW-1:0]          id_arr;
  assign val_arr = req_val_data;
  assign id_arr  = req_id_data;

  // First requester with a dictionary pending, scanning from rr_ptr and wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx_w      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx_w >= (PW+1)'(NUM_REQ)) idx_w = idx_w - (PW+1)'(NUM_REQ);
      if (!pick_found && req_val_valid[idx_w[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = idx_w[PW-1:0];
      end
    end
  end

  always_comb begin
    state_n        = state;
    req_val_ready  = '0;
    req_id_ready   = '0;
    rsp_valid      = '0;
    bank_val_valid = 1'b0;
    bank_val_last  = 1'b0;
    bank_val_data  = '0;
    bank_id_valid  = 1'b0;
    bank_id_last   = 1'b0;
    bank_id_data   = '0;
    bank_out_ready = 1'b0;
    round_end      = 1'b0;
    id_fire        = 1'b0;
    rsp_data       = bank_out_data;
    rsp_last       = bank_out_last;
    case (state)
      IDLE: if (pick_found) state_n = LOAD;
      LOAD: begin
        bank_val_valid      = req_val_valid[gidx];
        bank_val_last       = req_val_last[gidx];
        bank_val_data       = val_arr[gidx];
        req_val_ready[gidx] = bank_val_ready;
        if (req_val_valid[gidx] && bank_val_ready && req_val_last[gidx]) state_n = LOOKUP;
      end
      LOOKUP: begin
        bank_id_valid      = req_id_valid[gidx];
        bank_id_last       = req_id_last[gidx];
        bank_id_data       = id_arr[gidx];
        req_id_ready[gidx] = bank_id_ready;
        id_fire            = req_id_valid[gidx] && bank_id_ready;
        if (id_fire && req_id_last[gidx]) state_n = DRAIN;
      end
      default: ;
    endcase
    // Results are routed as soon as ids flow; a result-last seen in LOOKUP still closes the round.
    if (state == LOOKUP || state == DRAIN) begin
      rsp_valid[gidx] = bank_out_valid;
      bank_out_ready  = rsp_ready[gidx];
      round_end       = bank_out_valid && rsp_ready[gidx] && bank_out_last;
      if (round_end) state_n = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      gidx   <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && pick_found) begin
        grant <= NUM_REQ'(1) << pick_idx;
        gidx  <= pick_idx;
      end
      if (round_end) begin
        grant  <= '0;
        rr_ptr <= (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef DICT_BANK_SCHEDULER_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_rounds  <= '0;
      perf_lookups <= '0;
    end else begin
      if (round_end) perf_rounds  <= perf_rounds + 32'd1;
      if (id_fire)   perf_lookups <= perf_lookups + 32'd1;
    end
  end
`else
  assign perf_rounds  = '0;
  assign perf_lookups = '0;
`endif

endmodule

// File: tb/tb_dict_bank_scheduler.sv
// Randomized bench: requester streams and a behavioural dictionary bank, results checked per requester against a queue model.
module tb_dict_bank_scheduler;
  localparam int NR = 4, VW = 32, IDW = 10, SW = 16;
  localparam int IW = IDW + SW, RW = VW + SW;

  logic clk, rst;
  logic [NR-1:0]    req_val_valid, req_val_last, req_val_ready;
  logic [NR*VW-1:0] req_val_data;
  logic [NR-1:0]    req_id_valid, req_id_last, req_id_ready;
  logic [NR*IW-1:0] req_id_data;
  logic [NR-1:0]    rsp_valid, rsp_ready;
  logic [RW-1:0]    rsp_data;
  logic             rsp_last;
  logic             bank_val_valid, bank_val_last, bank_val_ready;
  logic [VW-1:0]    bank_val_data;
  logic             bank_id_valid, bank_id_last, bank_id_ready;
  logic [IW-1:0]    bank_id_data;
  logic             bank_out_valid, bank_out_last, bank_out_ready;
  logic [RW-1:0]    bank_out_data;
  logic [NR-1:0]    grant;
  logic             busy;
  logic [31:0]      perf_rounds, perf_lookups;

  dict_bank_scheduler #(.NUM_REQ(NR), .VALUE_WIDTH(VW), .ID_WIDTH(IDW), .SERIAL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .req_val_valid(req_val_valid), .req_val_last(req_val_last), .req_val_data(req_val_data), .req_val_ready(req_val_ready),
    .req_id_valid(req_id_valid), .req_id_last(req_id_last), .req_id_data(req_id_data), .req_id_ready(req_id_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
    .bank_val_valid(bank_val_valid), .bank_val_last(bank_val_last), .bank_val_data(bank_val_data), .bank_val_ready(bank_val_ready),
    .bank_id_valid(bank_id_valid), .bank_id_last(bank_id_last), .bank_id_data(bank_id_data), .bank_id_ready(bank_id_ready),
    .bank_out_valid(bank_out_valid), .bank_out_last(bank_out_last), .bank_out_data(bank_out_data), .bank_out_ready(bank_out_ready),
    .grant(grant), .busy(busy), .perf_rounds(perf_rounds), .perf_lookups(perf_lookups)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester jobs
  logic [VW-1:0]  dict [NR][16];
  logic [IDW-1:0] ids  [NR][16];
  logic [SW-1:0]  serl [NR][16];
  int dlen[NR], dptr[NR], ilen[NR], iptr[NR], rptr[NR], jobs[NR];
  bit armed[NR];
  // Bank model
  logic [VW-1:0] mem [1024];
  bit            bread;
  int            bwp;
  logic [RW:0]   bq[$];
  // Observation
  int owner;
  logic [NR-1:0] prev_grant;
  int glog[$];
  int hold_cnt;
  logic [RW-1:0] hold_data;
  bit gaps;
  int checks, failures;

  task automatic arm(input int j, input int nd, input int ni);
    dlen[j] = (nd > 0) ? nd : int'($urandom_range(1, 8));
    ilen[j] = (ni > 0) ? ni : int'($urandom_range(1, 5));
    for (int k = 0; k < dlen[j]; k++) dict[j][k] = $urandom;
    for (int k = 0; k < ilen[j]; k++) begin
      ids[j][k]  = IDW'($urandom_range(0, dlen[j] - 1));
      serl[j][k] = SW'($urandom);
    end
    dptr[j] = 0; iptr[j] = 0; rptr[j] = 0; armed[j] = 1'b1;
  endtask

  task automatic drive();
    for (int j = 0; j < NR; j++) begin
      req_val_valid[j] = armed[j] && dptr[j] < dlen[j] &&
                         !(gaps && owner == j && $urandom_range(0, 99) < 20);
      req_val_last[j]  = (dptr[j] == dlen[j] - 1);
      req_val_data[j*VW +: VW] = (dptr[j] < 16) ? dict[j][dptr[j]] : '0;
      req_id_valid[j]  = armed[j] && iptr[j] < ilen[j];
      req_id_last[j]   = (iptr[j] == ilen[j] - 1);
      req_id_data[j*IW +: IW] = (iptr[j] < 16) ? {serl[j][iptr[j]], ids[j][iptr[j]]} : '0;
      rsp_ready[j]     = (hold_cnt > 0) ? 1'b0 : (!gaps || $urandom_range(0, 99) < 75);
    end
    bank_val_ready = !bread && (!gaps || $urandom_range(0, 99) < 80);
    bank_id_ready  = bread && (!gaps || $urandom_range(0, 99) < 80);
    bank_out_valid = (bq.size() > 0);
    bank_out_data  = (bq.size() > 0) ? bq[0][RW-1:0] : '0;
    bank_out_last  = (bq.size() > 0) ? bq[0][RW] : 1'b0;
  endtask

  task automatic clear_model();
    for (int j = 0; j < NR; j++) begin
      armed[j] = 1'b0; dlen[j] = 0; ilen[j] = 0; dptr[j] = 0; iptr[j] = 0; rptr[j] = 0; jobs[j] = 0;
    end
    bq.delete(); bread = 1'b0; bwp = 0;
    owner = -1; prev_grant = '0; hold_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: sample and account for the handshakes of the coming edge, then drive new inputs.
  task automatic step();
    logic [RW:0]   h;
    logic [RW-1:0] e;
    @(negedge clk);
    if (grant === '0) owner = -1;
    else if (prev_grant === '0)
      for (int j = 0; j < NR; j++) if (grant[j]) begin owner = j; glog.push_back(j); end
    prev_grant = grant;
    if (hold_cnt > 0) begin
      checks++;
      if (bank_out_ready !== 1'b0 || rsp_data !== hold_data || owner < 0 || rsp_valid[owner] !== 1'b1) begin
        failures++;
        $display("FAIL hold_stall: bank_out_ready=%b rsp_data=%h want ready=0 data=%h valid=1", bank_out_ready, rsp_data, hold_data);
      end
      hold_cnt--;
    end
    for (int j = 0; j < NR; j++) begin
      checks++;
      if ((req_id_ready[j] || req_val_ready[j] || rsp_valid[j]) && j != owner) begin
        failures++;
        $display("FAIL leak req%0d: id_ready=%b val_ready=%b rsp_valid=%b while owner=%0d", j, req_id_ready[j], req_val_ready[j], rsp_valid[j], owner);
      end
    end
    if (bank_out_valid && bank_out_ready) begin
      h = bq.pop_front();
      if (h[RW]) begin bread = 1'b0; bwp = 0; end
    end
    for (int j = 0; j < NR; j++) if (rsp_valid[j] && rsp_ready[j] && armed[j] && rptr[j] < ilen[j]) begin
      e = {serl[j][rptr[j]], dict[j][ids[j][rptr[j]]]};
      checks++;
      if (rsp_data !== e || rsp_last !== (rptr[j] == ilen[j] - 1)) begin
        failures++;
        $display("FAIL rsp req%0d beat%0d: got %h last=%b want %h last=%b", j, rptr[j], rsp_data, rsp_last, e, rptr[j] == ilen[j] - 1);
      end
      rptr[j]++;
      if (rptr[j] == ilen[j]) begin
        armed[j] = 1'b0;
        if (jobs[j] > 0) begin jobs[j]--; arm(j, 0, 0); end
      end
    end
    if (bank_val_valid && bank_val_ready) begin
      checks++;
      if (owner < 0 || bank_val_data !== dict[owner][dptr[owner]] || bank_val_last !== (dptr[owner] == dlen[owner] - 1)) begin
        failures++;
        $display("FAIL bank_val: got %h last=%b owner=%0d", bank_val_data, bank_val_last, owner);
      end
      mem[bwp] = bank_val_data; bwp++;
      if (bank_val_last) bread = 1'b1;
    end
    for (int j = 0; j < NR; j++) if (req_val_valid[j] && req_val_ready[j]) dptr[j]++;
    if (bank_id_valid && bank_id_ready)
      bq.push_back({bank_id_last, bank_id_data[IW-1:IDW], mem[bank_id_data[IDW-1:0]]});
    for (int j = 0; j < NR; j++) if (req_id_valid[j] && req_id_ready[j]) iptr[j]++;
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit any_armed();
    bit a = 1'b0;
    for (int j = 0; j < NR; j++) a |= armed[j];
    return a;
  endfunction

  task automatic run_all(input string name, input int budget);
    int n = 0;
    while (any_armed() && n < budget) begin step(); n++; end
    repeat (3) step();
    checks++;
    if (any_armed()) begin failures++; $display("FAIL %s_timeout: jobs still pending after %0d cycles, want none", name, budget); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant !== '0 || busy !== 1'b0 || dut.rr_ptr !== '0 || req_val_ready !== '0 || req_id_ready !== '0 ||
        rsp_valid !== '0 || bank_val_valid !== 1'b0 || bank_id_valid !== 1'b0 || bank_out_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: grant=%b busy=%b rr=%0d vr=%b ir=%b rv=%b bvv=%b biv=%b bor=%b want all 0",
               grant, busy, dut.rr_ptr, req_val_ready, req_id_ready, rsp_valid, bank_val_valid, bank_id_valid, bank_out_ready);
    end
    checks++;
    if (perf_rounds !== 32'd0 || perf_lookups !== 32'd0) begin
      failures++; $display("FAIL reset_perf: rounds=%0d lookups=%0d want 0 0", perf_rounds, perf_lookups);
    end
  endtask

  task automatic test_single();
    gaps = 1'b1;
    glog.delete();
    dlen[0] = 4; ilen[0] = 3;
    dict[0][0] = 10; dict[0][1] = 11; dict[0][2] = 12; dict[0][3] = 13;
    ids[0][0] = 3; ids[0][1] = 0; ids[0][2] = 2;
    serl[0][0] = 7; serl[0][1] = 8; serl[0][2] = 9;
    dptr[0] = 0; iptr[0] = 0; rptr[0] = 0; armed[0] = 1'b1;
    drive();
    run_all("single", 300);
    checks++;
    if (glog.size() != 1 || glog[0] != 0) begin
      failures++; $display("FAIL single_grant: %0d grants, first=%0d want 1 grant to 0", glog.size(), glog.size() > 0 ? glog[0] : -1);
    end
    checks++;
    if (grant !== '0 || busy !== 1'b0 || dut.rr_ptr !== 2'd1) begin
      failures++; $display("FAIL single_end: grant=%b busy=%b rr=%0d want 0000 0 1", grant, busy, dut.rr_ptr);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    gaps = 1'b1;
    glog.delete();
    for (int j = 0; j < NR; j++) arm(j, 0, 0);
    jobs[0] = 1;
    drive();
    run_all("rr", 3000);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= glog.size() || glog[k] != exp_order[k]) begin
        failures++; $display("FAIL rr_order round%0d: got %0d want %0d", k, k < glog.size() ? glog[k] : -1, exp_order[k]);
      end
    end
    checks++;
    if (glog.size() != 5) begin failures++; $display("FAIL rr_count: got %0d rounds want 5", glog.size()); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    gaps = 1'b0;
    arm(1, 4, 6);
    drive();
    while (!(owner == 1 && rptr[1] >= 1 && rptr[1] < ilen[1] && bank_out_valid) && n < 200) begin step(); n++; end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL bp_start: no mid-packet result within 200 cycles, want one"); end
    hold_data = bank_out_data;
    hold_cnt  = 5;
    rsp_ready = '0;
    run_all("bp", 300);
    checks++;
    if (hold_cnt != 0) begin failures++; $display("FAIL bp_len: %0d hold cycles unchecked, want 0", hold_cnt); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    gaps = 1'b0;
    arm(3, 4, 5);
    drive();
    while (!(owner == 3 && dptr[3] == dlen[3] && iptr[3] < ilen[3] - 1) && n < 200) begin step(); n++; end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL mid_lookup: LOOKUP not reached within 200 cycles"); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0 || dut.rr_ptr !== '0 || req_val_ready !== '0 || req_id_ready !== '0 ||
        rsp_valid !== '0 || bank_val_valid !== 1'b0 || bank_id_valid !== 1'b0 || bank_out_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: grant=%b busy=%b rr=%0d ir=%b rv=%b biv=%b bor=%b want all 0",
               grant, busy, dut.rr_ptr, req_id_ready, rsp_valid, bank_id_valid, bank_out_ready);
    end
    clear_model();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_perf();
    do_reset();
    gaps = 1'b1;
    for (int j = 0; j < 3; j++) arm(j, 0, 5);
    drive();
    run_all("perf", 2000);
    checks++;
`ifdef DICT_BANK_SCHEDULER_PERF_EN
    if (perf_rounds !== 32'd3 || perf_lookups !== 32'd15) begin
      failures++; $display("FAIL perf: rounds=%0d lookups=%0d want 3 15", perf_rounds, perf_lookups);
    end
`else
    if (perf_rounds !== 32'd0 || perf_lookups !== 32'd0) begin
      failures++; $display("FAIL perf_off: rounds=%0d lookups=%0d want 0 0", perf_rounds, perf_lookups);
    end
`endif
  endtask

  initial begin
    checks = 0; failures = 0; gaps = 1'b0; hold_data = '0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
